// File: rtl/stopwatch_pkg.sv
// Shared display constants: digit geometry, active-high segment patterns {g,f,e,d,c,b,a}
// and the latched-per-frame display state.
package stopwatch_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef struct packed {
        logic [NUM_DIGITS*BCD_W-1:0] digits;
        logic [NUM_DIGITS-1:0]       dp;
        logic                        blank;
    } shadow_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-high seven-segment decoder; non-BCD codes show a dash.
// Zero latency, no flow control.
module bcd_to_seg
    import stopwatch_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed 4-digit seven-segment driver with dead time, frame snapshot, lap hold, zero blanking.
// Outputs registered (1-cycle latency); free-running scan, no backpressure.
module seven_seg_scan
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV    = 50_000,
    parameter int DEAD_CYC       = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_DIGITS*BCD_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       dp_mask,
    input  logic                        blank_lz,
    input  logic                        hold,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_done
);

    localparam int              CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   DEAD_LIM = CW'(DEAD_CYC);
    localparam logic            SEG_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic            AN_INV   = (AN_ACTIVE_LOW != 0);

    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    shadow_t         shadow;

    logic            slot_end;
    logic            frame_end;
    logic            on_phase;
    logic [BCD_W-1:0] cur_digit;
    logic [BCD_W-1:0] d3;
    logic [BCD_W-1:0] d2;
    logic            blanked;
    logic [6:0]      dec_seg;
    logic [6:0]      seg_nxt;
    logic            dp_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);
    assign on_phase  = (cnt >= DEAD_LIM);
    assign cur_digit = shadow.digits[{idx, 2'b00} +: BCD_W];
    assign d3        = shadow.digits[15:12];
    assign d2        = shadow.digits[11:8];

    bcd_to_seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Only the two leading positions may blank; the decimal point stays independent.
    always_comb begin
        blanked = 1'b0;
        if (shadow.blank) begin
            if (idx == 2'd3)
                blanked = (d3 == 4'd0);
            else if (idx == 2'd2)
                blanked = (d3 == 4'd0) && (d2 == 4'd0);
        end
    end

    always_comb begin
        an_nxt  = '0;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b0;
        if (on_phase) begin
            an_nxt  = 4'b0001 << idx;
            seg_nxt = blanked ? SEG_OFF : dec_seg;
            dp_nxt  = shadow.dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            idx        <= 2'd0;
            shadow     <= '0;
            frame_done <= 1'b0;
            seg        <= {7{SEG_INV}};
            dp         <= SEG_INV;
            an         <= {NUM_DIGITS{AN_INV}};
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= idx + 2'd1;
            frame_done <= frame_end;
            // Latch a coherent frame only at the boundary so a digit never tears mid-scan.
            if (frame_end && !hold)
                shadow <= '{digits: digits_in, dp: dp_mask, blank: blank_lz};
            seg        <= seg_nxt ^ {7{SEG_INV}};
            dp         <= dp_nxt ^ SEG_INV;
            an         <= an_nxt ^ {NUM_DIGITS{AN_INV}};
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with an 8-cycle slot, 2 dead cycles, active-low outputs.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_mask = 4'b0000;
    logic        blank_lz = 1'b0;
    logic        hold = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] L0 = 7'b1000000;
    localparam logic [6:0] L1 = 7'b1111001;
    localparam logic [6:0] L2 = 7'b0100100;
    localparam logic [6:0] L3 = 7'b0110000;
    localparam logic [6:0] L4 = 7'b0011001;
    localparam logic [6:0] L5 = 7'b0010010;
    localparam logic [6:0] L6 = 7'b0000010;
    localparam logic [6:0] L7 = 7'b1111000;
    localparam logic [6:0] L8 = 7'b0000000;
    localparam logic [6:0] L9 = 7'b0010000;
    localparam logic [6:0] LDASH = 7'b0111111;
    localparam logic [6:0] LOFF = 7'h7F;

    seven_seg_scan #(
        .REFRESH_DIV    (8),
        .DEAD_CYC       (2),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .hold       (hold),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one whole frame starting right after a frame_done cycle.
    task automatic expect_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpl);
        logic [6:0] es;
        logic [3:0] ea;
        logic       ed;
        logic       ef;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                if (c < 2) begin
                    ea = 4'b1111;
                    es = LOFF;
                    ed = 1'b1;
                end else begin
                    ea = ~(4'b0001 << s);
                    es = (s == 0) ? s0 : (s == 1) ? s1 : (s == 2) ? s2 : s3;
                    ed = ~dpl[s];
                end
                ef = (s == 3 && c == 7);
                vectors++;
                if (an !== ea || seg !== es || dp !== ed || frame_done !== ef) begin
                    miscompares++;
                    $display("FAIL %s slot%0d cyc%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                             name, s, c, an, seg, dp, frame_done, ea, es, ed, ef);
                end
            end
        end
    endtask

    task automatic wait_frame_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (frame_done === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s: frame_done not seen within 40 cycles, expected a pulse", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (an !== 4'b1111 || seg !== LOFF || dp !== 1'b1 || frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold%0d: an=%b seg=%b dp=%b fd=%b, expected 1111 1111111 1 0",
                         i, an, seg, dp, frame_done);
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++;
            if (i < 3) begin
                if (an !== 4'b1111 || seg !== LOFF) begin
                    miscompares++;
                    $display("FAIL reset_dead%0d: an=%b seg=%b, expected 1111 1111111", i, an, seg);
                end
            end else if (an !== 4'b1110 || seg !== L0 || dp !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_first_on: an=%b seg=%b dp=%b, expected 1110 %b 1", an, seg, dp, L0);
            end
        end
    endtask

    task automatic test_scan();
        digits_in = 16'h1234;
        wait_frame_done("scan_first_frame");
        expect_frame("scan_1234", L4, L3, L2, L1, 4'b0000);
    endtask

    task automatic test_snapshot();
        fork
            expect_frame("snap_old", L4, L3, L2, L1, 4'b0000);
            begin
                repeat (13) @(posedge clk);
                #2 digits_in = 16'h5678;
            end
        join
        expect_frame("snap_new", L8, L7, L6, L5, 4'b0000);
    endtask

    task automatic test_hold();
        digits_in = 16'h0059;
        expect_frame("hold_pre", L8, L7, L6, L5, 4'b0000);
        fork
            expect_frame("hold_0059", L9, L5, L0, L0, 4'b0000);
            begin
                repeat (10) @(posedge clk);
                #2 hold = 1'b1;
                digits_in = 16'h0060;
            end
        join
        fork
            expect_frame("hold_frozen", L9, L5, L0, L0, 4'b0000);
            begin
                repeat (20) @(posedge clk);
                #2 hold = 1'b0;
            end
        join
        expect_frame("hold_released", L0, L6, L0, L0, 4'b0000);
    endtask

    task automatic test_blank();
        blank_lz = 1'b1;
        digits_in = 16'h0005;
        dp_mask = 4'b0010;
        expect_frame("blank_pre", L0, L6, L0, L0, 4'b0000);
        fork
            expect_frame("blank_0005", L5, L0, LOFF, LOFF, 4'b0010);
            begin
                repeat (5) @(posedge clk);
                #2 digits_in = 16'h0A05;
            end
        join
        expect_frame("blank_dash", L5, L0, LDASH, LOFF, 4'b0010);
    endtask

    task automatic test_reset_mid();
        repeat (20) step();
        vectors++;
        if (an !== 4'b1011 || seg !== LDASH) begin
            miscompares++;
            $display("FAIL rmid_pre: an=%b seg=%b, expected 1011 %b", an, seg, LDASH);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (an !== 4'b1111 || seg !== LOFF || dp !== 1'b1 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_assert: an=%b seg=%b dp=%b fd=%b, expected 1111 1111111 1 0",
                     an, seg, dp, frame_done);
        end
        step();
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++;
            if (i < 3) begin
                if (an !== 4'b1111 || seg !== LOFF) begin
                    miscompares++;
                    $display("FAIL rmid_dead%0d: an=%b seg=%b, expected 1111 1111111", i, an, seg);
                end
            end else if (an !== 4'b1110 || seg !== L0 || dp !== 1'b1) begin
                miscompares++;
                $display("FAIL rmid_restart: an=%b seg=%b dp=%b, expected 1110 %b 1", an, seg, dp, L0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_hold();
        test_blank();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
